// File: rtl/compare_01.sv
// -----------------------------------------------------------------------------
// compare_01 : three-operand threshold-majority comparator
//
// Each of the three unsigned operands is classified as "high" when it is at or
// above THRESH and "low" otherwise. The block counts high and low operands and
// asserts RC when the low count does not exceed the high count. With three
// operands this is a majority vote of the high flags.
//
// RC, n_l and n_g are purely combinational from A/B/C. They do not depend on
// clk or rst_n, so they stay valid during reset and with the clock stopped.
// rc_q, n_l_q and n_g_q are registered copies with one cycle of latency. They
// sample on every rising clk edge and are cleared asynchronously by rst_n.
//
// Parameters
//   WIDTH   operand width in bits (minimum 2, at most 32)
//   THRESH  classification threshold, defaults to 2**(WIDTH-1)
//
// Ports
//   clk     system clock, rising edge active
//   rst_n   asynchronous active-low reset for the registered outputs
//   A,B,C   WIDTH-bit unsigned operands
//   RC      combinational result, 1 when n_l <= n_g
//   n_l     combinational count of low operands (0..3)
//   n_g     combinational count of high operands (0..3)
//   rc_q    RC registered on clk
//   n_l_q   n_l registered on clk
//   n_g_q   n_g registered on clk
// -----------------------------------------------------------------------------
module compare_01 #(
  parameter int WIDTH  = 4,
  parameter int THRESH = 2 ** (WIDTH - 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic             RC,
  output logic [1:0]       n_l,
  output logic [1:0]       n_g,
  output logic             rc_q,
  output logic [1:0]       n_l_q,
  output logic [1:0]       n_g_q
);

  // Threshold widened to 32 bits so the unsigned compare stays well defined
  // for any legal WIDTH, including a THRESH equal to 2**WIDTH.
  localparam logic [31:0] THRESH_U = 32'(THRESH);

  // Classify one operand. The operand is zero-extended before the compare so
  // that the comparison is unsigned regardless of the parameter's type.
  function automatic logic is_high(input logic [WIDTH-1:0] x);
    logic [31:0] x_ext;
    x_ext = 32'(x);
    return (x_ext >= THRESH_U);
  endfunction

  // Add three one-bit flags into a two-bit count (0..3 always fits).
  function automatic logic [1:0] count3(input logic f0,
                                        input logic f1,
                                        input logic f2);
    return {1'b0, f0} + {1'b0, f1} + {1'b0, f2};
  endfunction

  logic       high_a_s;
  logic       high_b_s;
  logic       high_c_s;
  logic [1:0] n_g_s;
  logic [1:0] n_l_s;
  logic       rc_s;

  // Per-operand classification and the derived counts and result.
  always_comb begin
    high_a_s = is_high(A);
    high_b_s = is_high(B);
    high_c_s = is_high(C);
    n_g_s    = count3(high_a_s, high_b_s, high_c_s);
    // The two counts always sum to three, so low count is the complement.
    n_l_s    = 2'd3 - n_g_s;
    if (n_l_s <= n_g_s) begin
      rc_s = 1'b1;
    end else begin
      rc_s = 1'b0;
    end
  end

  assign RC  = rc_s;
  assign n_l = n_l_s;
  assign n_g = n_g_s;

  // Registered copies for pipelined consumers; no enable, sample every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_q  <= 1'b0;
      n_l_q <= 2'd0;
      n_g_q <= 2'd0;
    end else begin
      rc_q  <= rc_s;
      n_l_q <= n_l_s;
      n_g_q <= n_g_s;
    end
  end

endmodule

// File: tb/tb_compare_01.sv
// -----------------------------------------------------------------------------
// tb_compare_01 : directed self-checking bench for compare_01
// -----------------------------------------------------------------------------
module tb_compare_01;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic [3:0] a_s;
  logic [3:0] b_s;
  logic [3:0] c_s;
  logic       rc_s;
  logic [1:0] n_l_s;
  logic [1:0] n_g_s;
  logic       rc_q_s;
  logic [1:0] n_l_q_s;
  logic [1:0] n_g_q_s;

  int n_checks;
  int n_fails;

  compare_01 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a_s),
    .B     (b_s),
    .C     (c_s),
    .RC    (rc_s),
    .n_l   (n_l_s),
    .n_g   (n_g_s),
    .rc_q  (rc_q_s),
    .n_l_q (n_l_q_s),
    .n_g_q (n_g_q_s)
  );

  // Gated clock so the combinational checks can run with the clock stopped.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c);
    a_s = a;
    b_s = b;
    c_s = c;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [1:0] nl;
    logic [1:0] ng;
    logic       rc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    n_checks = 0;
    n_fails  = 0;
    clk      = 1'b0;
    clk_en   = 1'b0;
    rst_n    = 1'b0;
    set_ops(4'd0, 4'd0, 4'd0);

    vecs[0] = '{4'd0,  4'd2,  4'd7,  2'd3, 2'd0, 1'b0};
    vecs[1] = '{4'd1,  4'd7,  4'd8,  2'd2, 2'd1, 1'b0};
    vecs[2] = '{4'd7,  4'd7,  4'd8,  2'd2, 2'd1, 1'b0};
    vecs[3] = '{4'd5,  4'd8,  4'd15, 2'd1, 2'd2, 1'b1};
    vecs[4] = '{4'd7,  4'd8,  4'd8,  2'd1, 2'd2, 1'b1};
    vecs[5] = '{4'd9,  4'd10, 4'd11, 2'd0, 2'd3, 1'b1};
    vecs[6] = '{4'd15, 4'd0,  4'd15, 2'd1, 2'd2, 1'b1};

    // Combinational path with clock stopped and reset asserted.
    #1;
    check_eq("reset_rc_q",  32'(rc_q_s),  32'd0);
    check_eq("reset_n_l_q", 32'(n_l_q_s), 32'd0);
    check_eq("reset_n_g_q", 32'(n_g_q_s), 32'd0);
    foreach (vecs[i]) begin
      set_ops(vecs[i].a, vecs[i].b, vecs[i].c);
      #5;
      check_eq($sformatf("vec%0d_n_l", i), 32'(n_l_s), 32'(vecs[i].nl));
      check_eq($sformatf("vec%0d_n_g", i), 32'(n_g_s), 32'(vecs[i].ng));
      check_eq($sformatf("vec%0d_rc", i),  32'(rc_s),  32'(vecs[i].rc));
    end

    // Registered path held in reset while RC is 1.
    set_ops(4'd9, 4'd10, 4'd11);
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("hold_rc",     32'(rc_s),    32'd1);
    check_eq("hold_rc_q",   32'(rc_q_s),  32'd0);
    check_eq("hold_n_g_q",  32'(n_g_q_s), 32'd0);
    check_eq("hold_n_l_q",  32'(n_l_q_s), 32'd0);

    // Release reset between edges; first capture at the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("pre_edge_rc_q", 32'(rc_q_s), 32'd0);
    @(posedge clk);
    #1;
    check_eq("first_rc_q",  32'(rc_q_s),  32'd1);
    check_eq("first_n_g_q", 32'(n_g_q_s), 32'd3);
    check_eq("first_n_l_q", 32'(n_l_q_s), 32'd0);

    // Input change shows on rc_q exactly one edge later.
    @(negedge clk);
    set_ops(4'd0, 4'd2, 4'd7);
    #1;
    check_eq("lat_comb_rc",   32'(rc_s),   32'd0);
    check_eq("lat_before_rc_q", 32'(rc_q_s), 32'd1);
    @(posedge clk);
    #1;
    check_eq("lat_after_rc_q",  32'(rc_q_s),  32'd0);
    check_eq("lat_after_n_l_q", 32'(n_l_q_s), 32'd3);
    check_eq("lat_after_n_g_q", 32'(n_g_q_s), 32'd0);

    // Mid-operation reset clears registers at once, comb path untouched.
    @(negedge clk);
    set_ops(4'd8, 4'd12, 4'd3);
    @(posedge clk);
    #2;
    check_eq("mid_pre_rc_q", 32'(rc_q_s), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rc_q",  32'(rc_q_s),  32'd0);
    check_eq("mid_n_l_q", 32'(n_l_q_s), 32'd0);
    check_eq("mid_n_g_q", 32'(n_g_q_s), 32'd0);
    check_eq("mid_rc",    32'(rc_s),    32'd1);
    check_eq("mid_n_g",   32'(n_g_s),   32'd2);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep: majority of MSBs, counts summing to three.
    for (int i = 0; i < 4096; i++) begin
      logic [11:0] v;
      int          msbs;
      v    = 12'(i);
      msbs = int'(v[11]) + int'(v[7]) + int'(v[3]);
      @(negedge clk);
      set_ops(v[11:8], v[7:4], v[3:0]);
      #1;
      check_eq($sformatf("sweep_rc_%0d", i), 32'(rc_s),
               (msbs >= 2) ? 32'd1 : 32'd0);
      check_eq($sformatf("sweep_sum_%0d", i),
               32'(n_l_s) + 32'(n_g_s), 32'd3);
      check_eq($sformatf("sweep_n_g_%0d", i), 32'(n_g_s), 32'(msbs));
      @(posedge clk);
      #1;
      check_eq($sformatf("sweep_n_g_q_%0d", i), 32'(n_g_q_s), 32'(msbs));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
